// File: rtl/net_sync_scheduler.sv
// ---------------------------------------------------------------------------
// net_sync_scheduler
//
// Schedules and supervises network time-sync attempts made by the
// internetTimeSet engine through its en/finished handshake.
//
// Handshake: sync_en is a registered request level. It is raised for exactly
// one attempt and held until the attempt ends. The attempt ends when
// sync_finished is seen, when the user starts adjusting time (abort), or when
// the watchdog expires. sync_en is always low for at least one cycle between
// two attempts. sync_finished is only sampled while the FSM is in RUN.
//
// A sync starts once after reset, every SYNC_PERIOD_S seconds, or when
// manual_req is pulsed. Failed attempts are retried up to MAX_RETRY times,
// with RETRY_GAP_S seconds between them.
//
// Ports
//   clk            in   system clock
//   reset          in   asynchronous, active-high reset
//   manual_req     in   one-cycle pulse: request an immediate sync
//   adjust_active  in   level: user is editing time/date, syncing forbidden
//   sync_finished  in   finished from internetTimeSet (sampled in RUN only)
//   sync_en        out  en to internetTimeSet, registered, high only in RUN
//   busy           out  high in PENDING, RUN or GAP
//   sync_ok        out  one-cycle pulse: attempt completed
//   sync_fail      out  one-cycle pulse: all retries exhausted
//   last_ok        out  result of the last completed sequence
//   retry_cnt      out  failed attempts in the current sequence
//   secs_to_next   out  seconds left before the next scheduled sync (IDLE)
//   dbg_state      out  current FSM state (0 IDLE, 1 PENDING, 2 RUN, 3 GAP)
// ---------------------------------------------------------------------------
module net_sync_scheduler #(
    parameter int CLK_HZ        = 100_000_000,
    parameter int SYNC_PERIOD_S = 3600,
    parameter int TIMEOUT_S     = 5,
    parameter int RETRY_GAP_S   = 10,
    parameter int MAX_RETRY     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        manual_req,
    input  logic        adjust_active,
    input  logic        sync_finished,
    output logic        sync_en,
    output logic        busy,
    output logic        sync_ok,
    output logic        sync_fail,
    output logic        last_ok,
    output logic [2:0]  retry_cnt,
    output logic [15:0] secs_to_next,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_RUN     = 2'd2,
        S_GAP     = 2'd3
    } state_t;

    localparam int             PW     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]  P_MAX  = PW'(CLK_HZ - 1);
    localparam logic [15:0]    PERIOD = 16'(SYNC_PERIOD_S);
    localparam logic [7:0]     TMO    = 8'(TIMEOUT_S);
    localparam logic [7:0]     GAP    = 8'(RETRY_GAP_S);
    localparam logic [2:0]     RMAX   = 3'(MAX_RETRY);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_presc;
    logic          w_tick;

    logic          r_sync_en,  w_sync_en_nxt;
    logic          r_sync_ok,  w_sync_ok_nxt;
    logic          r_sync_fail, w_sync_fail_nxt;
    logic          r_last_ok,  w_last_ok_nxt;
    logic [2:0]    r_retry,    w_retry_nxt;
    logic [15:0]   r_secs,     w_secs_nxt;
    logic [7:0]    r_wd,       w_wd_nxt;
    logic [7:0]    r_gap,      w_gap_nxt;

    // Free-running 1 Hz prescaler; never realigned to sync events.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (r_presc == P_MAX) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    assign w_tick = (r_presc == P_MAX);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_PENDING;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-value logic. A counter "expires" on the tick that
    // takes it from 1 to 0 (or immediately if it is already 0), so each
    // interval is a whole number of ticks long.
    always_comb begin
        w_state_nxt     = r_state;
        w_sync_ok_nxt   = 1'b0;
        w_sync_fail_nxt = 1'b0;
        w_last_ok_nxt   = r_last_ok;
        w_retry_nxt     = r_retry;
        w_secs_nxt      = r_secs;
        w_wd_nxt        = r_wd;
        w_gap_nxt       = r_gap;

        case (r_state)
            S_IDLE: begin
                if (w_tick && (r_secs != 16'd0)) begin
                    w_secs_nxt = r_secs - 16'd1;
                end
                if (manual_req || (w_tick && (r_secs <= 16'd1))) begin
                    w_state_nxt = S_PENDING;
                    w_retry_nxt = 3'd0;
                end
            end

            S_PENDING: begin
                if (!adjust_active) begin
                    w_state_nxt = S_RUN;
                    w_wd_nxt    = TMO;
                end
            end

            S_RUN: begin
                if (sync_finished) begin
                    // Finished beats a simultaneous watchdog expiry.
                    w_state_nxt   = S_IDLE;
                    w_sync_ok_nxt = 1'b1;
                    w_last_ok_nxt = 1'b1;
                    w_retry_nxt   = 3'd0;
                    w_secs_nxt    = PERIOD;
                end else if (adjust_active) begin
                    // Abort without counting a failure.
                    w_state_nxt = S_PENDING;
                end else begin
                    if (w_tick && (r_wd != 8'd0)) begin
                        w_wd_nxt = r_wd - 8'd1;
                    end
                    if ((r_wd == 8'd0) || (w_tick && (r_wd == 8'd1))) begin
                        if (r_retry < RMAX) begin
                            w_retry_nxt = r_retry + 3'd1;
                            w_gap_nxt   = GAP;
                            w_state_nxt = S_GAP;
                        end else begin
                            w_sync_fail_nxt = 1'b1;
                            w_last_ok_nxt   = 1'b0;
                            w_secs_nxt      = PERIOD;
                            w_state_nxt     = S_IDLE;
                        end
                    end
                end
            end

            S_GAP: begin
                if (w_tick && (r_gap != 8'd0)) begin
                    w_gap_nxt = r_gap - 8'd1;
                end
                if (manual_req || (r_gap == 8'd0) || (w_tick && (r_gap == 8'd1))) begin
                    w_state_nxt = S_PENDING;
                end
            end

            default: begin
                w_state_nxt = S_PENDING;
            end
        endcase

        // Registered enable follows the state being entered, so it rises one
        // cycle after the PENDING decision and falls with the RUN exit.
        w_sync_en_nxt = (w_state_nxt == S_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_en   <= 1'b0;
            r_sync_ok   <= 1'b0;
            r_sync_fail <= 1'b0;
            r_last_ok   <= 1'b0;
            r_retry     <= 3'd0;
            r_secs      <= PERIOD;
            r_wd        <= 8'd0;
            r_gap       <= 8'd0;
        end else begin
            r_sync_en   <= w_sync_en_nxt;
            r_sync_ok   <= w_sync_ok_nxt;
            r_sync_fail <= w_sync_fail_nxt;
            r_last_ok   <= w_last_ok_nxt;
            r_retry     <= w_retry_nxt;
            r_secs      <= w_secs_nxt;
            r_wd        <= w_wd_nxt;
            r_gap       <= w_gap_nxt;
        end
    end

    assign sync_en      = r_sync_en;
    assign busy         = (r_state != S_IDLE);
    assign sync_ok      = r_sync_ok;
    assign sync_fail    = r_sync_fail;
    assign last_ok      = r_last_ok;
    assign retry_cnt    = r_retry;
    assign secs_to_next = r_secs;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_net_sync_scheduler.sv
// Bench for net_sync_scheduler with CLK_HZ=10, SYNC_PERIOD_S=5, TIMEOUT_S=3,
// RETRY_GAP_S=2, MAX_RETRY=2. One tick every 10 clocks, on the edges whose
// post-reset edge number is a multiple of 10.
module tb_net_sync_scheduler;

    localparam logic [1:0] ST_IDLE = 2'd0, ST_PEND = 2'd1, ST_RUN = 2'd2, ST_GAP = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        manual_req = 1'b0;
    logic        adjust_active = 1'b0;
    logic        sync_finished = 1'b0;
    logic        sync_en, busy, sync_ok, sync_fail, last_ok;
    logic [2:0]  retry_cnt;
    logic [15:0] secs_to_next;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    // Edge number since reset release; used to predict tick positions.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    net_sync_scheduler #(
        .CLK_HZ(10), .SYNC_PERIOD_S(5), .TIMEOUT_S(3), .RETRY_GAP_S(2), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .reset(reset), .manual_req(manual_req), .adjust_active(adjust_active),
        .sync_finished(sync_finished), .sync_en(sync_en), .busy(busy), .sync_ok(sync_ok),
        .sync_fail(sync_fail), .last_ok(last_ok), .retry_cnt(retry_cnt),
        .secs_to_next(secs_to_next), .dbg_state(dbg_state)
    );

    // Wait on negedges until sync_en equals val, at most max cycles.
    task automatic wait_en(input logic val, input int max, output bit to);
        int n;
        n = 0;
        to = 1'b0;
        while (sync_en !== val) begin
            if (n >= max) begin
                to = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pulse_manual();
        manual_req = 1'b1;
        @(negedge clk);
        manual_req = 1'b0;
    endtask

    // {sync_en,busy,sync_ok,sync_fail,last_ok,retry_cnt,secs_to_next,state}
    task automatic test_reset();
        logic [25:0] obs, exp_v;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        obs   = {sync_en, busy, sync_ok, sync_fail, last_ok, retry_cnt, secs_to_next, dbg_state};
        exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd5, ST_PEND};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL reset_values got=%h exp=%h", obs, exp_v);
        end
    endtask

    task automatic test_first_sync();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (sync_en !== 1'b1 || dbg_state !== ST_RUN || busy !== 1'b1) begin
            failures++;
            $display("FAIL first_en got en=%b st=%0d busy=%b exp en=1 st=2 busy=1", sync_en, dbg_state, busy);
        end
        repeat (16) @(negedge clk);
        sync_finished = 1'b1;
        @(negedge clk);
        sync_finished = 1'b0;
        checks++;
        if (sync_ok !== 1'b1 || sync_en !== 1'b0 || last_ok !== 1'b1 || secs_to_next !== 16'd5 ||
            dbg_state !== ST_IDLE || busy !== 1'b0 || retry_cnt !== 3'd0) begin
            failures++;
            $display("FAIL first_ok got ok=%b en=%b lok=%b secs=%0d st=%0d busy=%b rc=%0d exp 1 0 1 5 0 0 0",
                     sync_ok, sync_en, last_ok, secs_to_next, dbg_state, busy, retry_cnt);
        end
        @(negedge clk);
        checks++;
        if (sync_ok !== 1'b0) begin
            failures++;
            $display("FAIL ok_one_cycle got=%b exp=0", sync_ok);
        end
    endtask

    task automatic test_idle_countdown();
        logic [15:0] last;
        int decs, t0, n;
        last = 16'd5;
        decs = 0;
        t0   = cyc - 1;
        n    = 0;
        while (sync_en !== 1'b1 && n < 100) begin
            if (dbg_state == ST_IDLE && secs_to_next !== last) begin
                checks++;
                if (secs_to_next !== last - 16'd1) begin
                    failures++;
                    $display("FAIL countdown_step got=%0d exp=%0d", secs_to_next, last - 16'd1);
                end
                last = secs_to_next;
                decs++;
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (sync_en !== 1'b1 || decs != 4 || (cyc - t0) < 40 || (cyc - t0) > 60) begin
            failures++;
            $display("FAIL countdown_period got en=%b steps=%0d cycles=%0d exp en=1 steps=4 cycles=40..60",
                     sync_en, decs, cyc - t0);
        end
    endtask

    task automatic test_retry_fail();
        bit to;
        int t_rise, t_fall, len;
        t_fall = -1;
        for (int a = 0; a < 3; a++) begin
            wait_en(1'b1, 100, to);
            t_rise = cyc;
            if (t_fall >= 0) begin
                checks++;
                if (to || (t_rise - t_fall) < 18 || (t_rise - t_fall) > 25) begin
                    failures++;
                    $display("FAIL gap_len attempt=%0d got=%0d timeout=%b exp=18..25", a, t_rise - t_fall, to);
                end
            end
            wait_en(1'b0, 60, to);
            t_fall = cyc;
            len = t_fall - t_rise;
            checks++;
            if (to || len < 25 || len > 35) begin
                failures++;
                $display("FAIL attempt_len attempt=%0d got=%0d timeout=%b exp=25..35", a, len, to);
            end
            checks++;
            if (a < 2) begin
                if (retry_cnt !== 3'(a + 1) || dbg_state !== ST_GAP || sync_fail !== 1'b0) begin
                    failures++;
                    $display("FAIL retry_step got rc=%0d st=%0d fail=%b exp rc=%0d st=3 fail=0",
                             retry_cnt, dbg_state, sync_fail, a + 1);
                end
            end else begin
                if (sync_fail !== 1'b1 || sync_ok !== 1'b0 || last_ok !== 1'b0 ||
                    dbg_state !== ST_IDLE || retry_cnt !== 3'd2 || secs_to_next !== 16'd5) begin
                    failures++;
                    $display("FAIL exhausted got fail=%b ok=%b lok=%b st=%0d rc=%0d secs=%0d exp 1 0 0 0 2 5",
                             sync_fail, sync_ok, last_ok, dbg_state, retry_cnt, secs_to_next);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (sync_fail !== 1'b0) begin
            failures++;
            $display("FAIL fail_one_cycle got=%b exp=0", sync_fail);
        end
    endtask

    task automatic test_manual_idle();
        int n;
        n = 0;
        while (secs_to_next !== 16'd4 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (secs_to_next !== 16'd4 || dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL idle_secs4 got secs=%0d st=%0d exp secs=4 st=0", secs_to_next, dbg_state);
        end
        pulse_manual();
        checks++;
        if (dbg_state !== ST_PEND || sync_en !== 1'b0 || retry_cnt !== 3'd0) begin
            failures++;
            $display("FAIL manual_idle_pend got st=%0d en=%b rc=%0d exp st=1 en=0 rc=0", dbg_state, sync_en, retry_cnt);
        end
        @(negedge clk);
        checks++;
        if (sync_en !== 1'b1) begin
            failures++;
            $display("FAIL manual_idle_en got=%b exp=1", sync_en);
        end
    endtask

    task automatic test_manual_gap();
        bit to;
        wait_en(1'b0, 40, to);
        checks++;
        if (to || dbg_state !== ST_GAP || retry_cnt !== 3'd1) begin
            failures++;
            $display("FAIL gap_entry got st=%0d rc=%0d timeout=%b exp st=3 rc=1", dbg_state, retry_cnt, to);
        end
        pulse_manual();
        checks++;
        if (dbg_state !== ST_PEND || sync_en !== 1'b0) begin
            failures++;
            $display("FAIL manual_gap_pend got st=%0d en=%b exp st=1 en=0", dbg_state, sync_en);
        end
        @(negedge clk);
        checks++;
        if (sync_en !== 1'b1 || retry_cnt !== 3'd1) begin
            failures++;
            $display("FAIL manual_gap_en got en=%b rc=%0d exp en=1 rc=1", sync_en, retry_cnt);
        end
    endtask

    task automatic test_adjust_abort();
        bit leak;
        repeat (3) @(negedge clk);
        adjust_active = 1'b1;
        @(negedge clk);
        checks++;
        if (sync_en !== 1'b0 || dbg_state !== ST_PEND || retry_cnt !== 3'd1) begin
            failures++;
            $display("FAIL abort got en=%b st=%0d rc=%0d exp en=0 st=1 rc=1", sync_en, dbg_state, retry_cnt);
        end
        leak = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sync_en !== 1'b0 || sync_fail !== 1'b0) leak = 1'b1;
        end
        checks++;
        if (leak) begin
            failures++;
            $display("FAIL abort_hold got en_or_fail_high=1 exp=0");
        end
        adjust_active = 1'b0;
        @(negedge clk);
        checks++;
        if (sync_en !== 1'b1 || retry_cnt !== 3'd1 || sync_fail !== 1'b0 || dbg_state !== ST_RUN) begin
            failures++;
            $display("FAIL abort_resume got en=%b rc=%0d fail=%b st=%0d exp en=1 rc=1 fail=0 st=2",
                     sync_en, retry_cnt, sync_fail, dbg_state);
        end
    endtask

    // Attempt started at edge r; watchdog expires on the third tick edge after r.
    task automatic test_finish_vs_expire();
        int e, n;
        e = ((cyc / 10) + 3) * 10;
        n = 0;
        while (cyc < e - 1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sync_en !== 1'b1 || cyc != e - 1) begin
            failures++;
            $display("FAIL pre_expire got en=%b cyc=%0d exp en=1 cyc=%0d", sync_en, cyc, e - 1);
        end
        sync_finished = 1'b1;
        @(negedge clk);
        sync_finished = 1'b0;
        checks++;
        if (sync_ok !== 1'b1 || sync_fail !== 1'b0 || dbg_state !== ST_IDLE ||
            retry_cnt !== 3'd0 || last_ok !== 1'b1 || sync_en !== 1'b0) begin
            failures++;
            $display("FAIL finish_wins got ok=%b fail=%b st=%0d rc=%0d lok=%b en=%b exp 1 0 0 0 1 0",
                     sync_ok, sync_fail, dbg_state, retry_cnt, last_ok, sync_en);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [25:0] obs, exp_v;
        pulse_manual();
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (sync_en !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_en got=%b exp=0", sync_en);
        end
        obs   = {sync_en, busy, sync_ok, sync_fail, last_ok, retry_cnt, secs_to_next, dbg_state};
        exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd5, ST_PEND};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL reset_mid_values got=%h exp=%h", obs, exp_v);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (sync_en !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_en got=%b exp=1", sync_en);
        end
    endtask

    initial begin
        test_reset();
        test_first_sync();
        test_idle_countdown();
        test_retry_fail();
        test_manual_idle();
        test_manual_gap();
        test_adjust_abort();
        test_finish_vs_expire();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

endmodule
